load_store_unit: RTL

//  MEM-stage initiator for the byte-addressed data memory port (MEM_V/r_w/size/address/data_in/data_out).

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a single-cycle byte-addressed data memory port.
// Define LSU_STATS_EN to add the stat_loads/stat_stores/stat_faults counters.
module load_store_unit #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [RD_W-1:0] req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [RD_W-1:0] resp_rd,
    output logic            resp_error,
    output logic            MEM_V,
    output logic            MEM_RW,
    output logic [2:0]      MEM_SIZE,
    output logic [XLEN-1:0] MEM_ADDR,
    output logic [XLEN-1:0] MEM_WDATA,
    input  logic [XLEN-1:0] MEM_RDATA
`ifdef LSU_STATS_EN
    ,
    output logic [31:0]     stat_loads,
    output logic [31:0]     stat_stores,
    output logic [31:0]     stat_faults
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0] state_r;
    logic       store_r;
    logic [2:0] funct3_r;
    logic       misalign_s;
    logic       illegal_s;
    logic       error_s;
    logic [2:0] size_s;

    function automatic logic [XLEN-1:0] extend_load(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){d[7]}}, d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b010:  r = {{(XLEN-32){d[31]}}, d[31:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, d[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, d[15:0]};
            3'b110:  r = {{(XLEN-32){1'b0}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request decode: alignment, legality and memory size code of the presented request
    always_comb begin
        misalign_s = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_s = req_addr[0];
            2'b10:   misalign_s = |req_addr[1:0];
            2'b11:   misalign_s = |req_addr[2:0];
            default: misalign_s = 1'b0;
        endcase
        illegal_s = (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        error_s   = misalign_s || illegal_s;
        // Doubleword reads use size code 6 on this memory port
        if (!req_store && (req_funct3[1:0] == 2'b11)) begin
            size_s = 3'b110;
        end else begin
            size_s = {1'b0, req_funct3[1:0]};
        end
    end

    // Control FSM with registered request, memory and response outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            store_r    <= 1'b0;
            funct3_r   <= 3'b000;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= {XLEN{1'b0}};
            resp_rd    <= {RD_W{1'b0}};
            resp_error <= 1'b0;
            MEM_V      <= 1'b0;
            MEM_RW     <= 1'b0;
            MEM_SIZE   <= 3'b000;
            MEM_ADDR   <= {XLEN{1'b0}};
            MEM_WDATA  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        store_r   <= req_store;
                        funct3_r  <= req_funct3;
                        MEM_ADDR  <= req_addr;
                        MEM_WDATA <= req_wdata;
                        resp_rd   <= req_rd;
                        req_ready <= 1'b0;
                        if (error_s) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_data  <= {XLEN{1'b0}};
                        end else begin
                            state_r  <= ST_ACCESS;
                            MEM_V    <= 1'b1;
                            MEM_RW   <= req_store;
                            MEM_SIZE <= size_s;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    state_r    <= ST_RESP;
                    MEM_V      <= 1'b0;
                    MEM_RW     <= 1'b0;
                    MEM_SIZE   <= 3'b000;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_data  <= store_r ? {XLEN{1'b0}} : extend_load(funct3_r, MEM_RDATA);
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end else begin
                        resp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    MEM_V      <= 1'b0;
                    MEM_RW     <= 1'b0;
                    MEM_SIZE   <= 3'b000;
                end
            endcase
        end
    end

`ifdef LSU_STATS_EN
    // Activity counters: loads/stores at the end of ACCESS, faults on error accept
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stat_loads  <= 32'd0;
            stat_stores <= 32'd0;
            stat_faults <= 32'd0;
        end else begin
            if (state_r == ST_ACCESS && store_r) begin
                stat_stores <= stat_stores + 32'd1;
            end else if (state_r == ST_ACCESS) begin
                stat_loads <= stat_loads + 32'd1;
            end else begin
                stat_loads <= stat_loads;
            end
            if (state_r == ST_IDLE && req_valid && error_s) begin
                stat_faults <= stat_faults + 32'd1;
            end else begin
                stat_faults <= stat_faults;
            end
        end
    end
`endif

endmodule
